// File: rtl/uns_6by3_div.sv
// Unsigned sequential divider: repeatedly subtracts the captured divisor from the
// dividend and counts the subtractions, reporting quotient, remainder and divide-by-zero.
module uns_6by3_div #(
  parameter int N_W = 6,
  parameter int D_W = 3
) (
  input  logic           SYS_CLOCK,
  input  logic           FSM_ARESET,
  input  logic           GO,
  input  logic [N_W-1:0] N,
  input  logic [D_W-1:0] D,
  output logic [N_W-1:0] Q_REG,
  output logic [D_W-1:0] R_REG,
  output logic           DIV_BY_ZERO,
  output logic           BUSY,
  output logic           DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_SUB,
    S_FINISH
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic [D_W-1:0] r_d;
  logic [N_W-1:0] r_r1;
  logic [N_W-1:0] r_qcnt;
  logic [N_W-1:0] r_q;
  logic [D_W-1:0] r_r;
  logic           r_dbz;
  logic           r_busy;
  logic           r_done;

  logic [N_W-1:0] w_d_ext;
  logic           w_dz;
  logic           w_ge;

  assign w_d_ext = N_W'(r_d);
  assign w_dz    = (r_d == '0);
  assign w_ge    = (r_r1 >= w_d_ext);

  always_ff @(posedge SYS_CLOCK) begin
    if (FSM_ARESET) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (GO) w_next = S_CHECK;
      S_CHECK:  w_next = (!w_dz && w_ge) ? S_SUB : S_FINISH;
      S_SUB:    w_next = S_CHECK;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath and result registers; results only move on the edge entering FINISH.
  always_ff @(posedge SYS_CLOCK) begin
    if (FSM_ARESET) begin
      r_d    <= '0;
      r_r1   <= '0;
      r_qcnt <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_dbz  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (GO) begin
            r_d    <= D;
            r_r1   <= N;
            r_qcnt <= '0;
            r_busy <= 1'b1;
          end
        end
        S_CHECK: begin
          if (w_dz) begin
            r_q    <= '1;
            r_r    <= '0;
            r_dbz  <= 1'b1;
            r_done <= 1'b1;
          end else if (!w_ge) begin
            r_q    <= r_qcnt;
            r_r    <= r_r1[D_W-1:0];
            r_dbz  <= 1'b0;
            r_done <= 1'b1;
          end
        end
        S_SUB: begin
          r_r1   <= r_r1 - w_d_ext;
          r_qcnt <= r_qcnt + N_W'(1);
        end
        S_FINISH: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign Q_REG       = r_q;
  assign R_REG       = r_r;
  assign DIV_BY_ZERO = r_dbz;
  assign BUSY        = r_busy;
  assign DONE        = r_done;

endmodule

// File: tb/tb_uns_6by3_div.sv
// Bench for uns_6by3_div: directed scenarios plus random operands checked against
// plain integer division and the 2q+2 latency rule.
module tb_uns_6by3_div;

  logic       SYS_CLOCK = 1'b0;
  logic       FSM_ARESET;
  logic       GO;
  logic [5:0] N;
  logic [2:0] D;
  logic [5:0] Q_REG;
  logic [2:0] R_REG;
  logic       DIV_BY_ZERO;
  logic       BUSY;
  logic       DONE;

  int tests = 0;
  int fails = 0;
  int exp_q = 0;
  int exp_r = 0;
  int exp_dbz = 0;

  uns_6by3_div #(.N_W(6), .D_W(3)) dut (
    .SYS_CLOCK   (SYS_CLOCK),
    .FSM_ARESET  (FSM_ARESET),
    .GO          (GO),
    .N           (N),
    .D           (D),
    .Q_REG       (Q_REG),
    .R_REG       (R_REG),
    .DIV_BY_ZERO (DIV_BY_ZERO),
    .BUSY        (BUSY),
    .DONE        (DONE)
  );

  always #5 SYS_CLOCK = ~SYS_CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present operands at the falling edge and hold GO through the next rising edge.
  task automatic start_op(input int n, input int d, input bit keep_go);
    @(negedge SYS_CLOCK);
    N  = 6'(n);
    D  = 3'(d);
    GO = 1'b1;
    @(posedge SYS_CLOCK);
    #1;
    if (!keep_go) GO = 1'b0;
  endtask

  // Called #1 after the accepting edge; follows the operation to its DONE pulse.
  task automatic wait_done(input int n, input int d);
    int q, r, dbz, lat, edges;
    bit seen;
    if (d == 0) begin
      q = 63; r = 0; dbz = 1; lat = 2;
    end else begin
      q = n / d; r = n % d; dbz = 0; lat = 2 * q + 2;
    end
    edges = 1;
    seen  = 1'b0;
    check("busy_accept", BUSY, 1);
    while (!seen && edges < 300) begin
      check("q_hold", Q_REG, exp_q);
      @(posedge SYS_CLOCK);
      #1;
      edges++;
      if (DONE) seen = 1'b1;
      else      check("busy_run", BUSY, 1);
    end
    check("done_seen", seen, 1);
    check("latency", edges, lat);
    check("quotient", Q_REG, q);
    check("remainder", R_REG, r);
    check("div_by_zero", DIV_BY_ZERO, dbz);
    check("busy_at_done", BUSY, 1);
    exp_q = q; exp_r = r; exp_dbz = dbz;
    @(posedge SYS_CLOCK);
    #1;
    check("done_pulse", DONE, 0);
    check("busy_clear", BUSY, 0);
    check("q_after", Q_REG, exp_q);
  endtask

  task automatic do_op(input int n, input int d);
    start_op(n, d, 1'b0);
    wait_done(n, d);
  endtask

  initial begin
    int dn, dd;
    bit done_seen;
    FSM_ARESET = 1'b1;
    GO = 1'b0;
    N  = '0;
    D  = '0;
    repeat (2) @(posedge SYS_CLOCK);
    #1;
    check("rst_q", Q_REG, 0);
    check("rst_r", R_REG, 0);
    check("rst_dbz", DIV_BY_ZERO, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    FSM_ARESET = 1'b0;

    do_op(13, 3);
    do_op(63, 1);
    do_op(42, 7);
    do_op(5, 7);
    do_op(0, 4);
    do_op(20, 0);
    do_op(20, 6);

    // Operand changes after acceptance must not matter.
    start_op(50, 3, 1'b0);
    N = 6'd1; D = 3'd1;
    wait_done(50, 3);

    // Mid-operation reset abandons the work with no DONE.
    start_op(63, 2, 1'b0);
    repeat (3) @(posedge SYS_CLOCK);
    @(negedge SYS_CLOCK);
    FSM_ARESET = 1'b1;
    @(posedge SYS_CLOCK);
    #1;
    FSM_ARESET = 1'b0;
    check("mrst_q", Q_REG, 0);
    check("mrst_r", R_REG, 0);
    check("mrst_dbz", DIV_BY_ZERO, 0);
    check("mrst_busy", BUSY, 0);
    check("mrst_done", DONE, 0);
    done_seen = 1'b0;
    repeat (10) begin
      @(posedge SYS_CLOCK);
      #1;
      if (DONE) done_seen = 1'b1;
    end
    check("mrst_no_done", done_seen, 0);
    exp_q = 0; exp_r = 0; exp_dbz = 0;
    do_op(9, 4);

    // Reset coincident with GO: nothing starts.
    @(negedge SYS_CLOCK);
    N = 6'd30; D = 3'd5; GO = 1'b1; FSM_ARESET = 1'b1;
    @(posedge SYS_CLOCK);
    #1;
    FSM_ARESET = 1'b0; GO = 1'b0;
    check("rstgo_busy", BUSY, 0);
    @(posedge SYS_CLOCK);
    #1;
    check("rstgo_busy2", BUSY, 0);
    check("rstgo_q", Q_REG, 0);
    exp_q = 0;

    // GO held high: GO while busy is ignored, next op starts after FINISH.
    start_op(7, 2, 1'b1);
    N = 6'd1; D = 3'd1;
    wait_done(7, 2);
    @(posedge SYS_CLOCK);
    #1;
    GO = 1'b0;
    wait_done(1, 1);

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 25; i++) begin
      dn = int'($urandom_range(0, 63));
      dd = int'($urandom_range(0, 7));
      do_op(dn, dd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
